// File: rtl/alu_execute_unit.sv
// -----------------------------------------------------------------------------
// alu_execute_unit
//
// Execute stage of a single-cycle LEGv8-style datapath. It contains three
// pieces of logic:
//   * ALU-control decode, from ALUOp and the R-type opcode field
//   * a WIDTH-bit ALU with zero, carry and signed-overflow flags
//   * two adders, one for pc + PC_INCREMENT and one for the branch target
// Every output is registered, so results appear one cycle after the inputs.
// The outputs load on every clock edge, whether or not in_valid is set.
// Consumers qualify the outputs with out_valid.
//
// Ports:
//   clock            rising-edge clock
//   reset            asynchronous, active-low reset
//   in_valid         operands and controls valid this cycle
//   alu_op1/alu_op0  ALUOp from the control unit
//   instruction_part instruction[31:21] opcode field
//   input_data_1     operand A (Rn data)
//   input_data_2     operand B (ALUSrc mux output)
//   pc               current PC
//   branch_offset    sign-extended offset, already shifted left by 2
//   out_valid        registered copy of in_valid
//   operation_code   registered decoded ALU operation
//   output_data      registered ALU result
//   output_zero      registered (output_data == 0)
//   output_carry     registered carry-out; 0 unless the op is add or subtract
//   output_overflow  registered signed overflow; 0 unless add or subtract
//   illegal_op       registered: the R-type opcode was not recognised
//   pc_plus_4        registered pc + PC_INCREMENT
//   branch_target    registered pc + branch_offset
// -----------------------------------------------------------------------------
module alu_execute_unit #(
  parameter int WIDTH        = 64,
  parameter int PC_INCREMENT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             alu_op1,
  input  logic             alu_op0,
  input  logic [10:0]      instruction_part,
  input  logic [WIDTH-1:0] input_data_1,
  input  logic [WIDTH-1:0] input_data_2,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] branch_offset,
  output logic             out_valid,
  output logic [3:0]       operation_code,
  output logic [WIDTH-1:0] output_data,
  output logic             output_zero,
  output logic             output_carry,
  output logic             output_overflow,
  output logic             illegal_op,
  output logic [WIDTH-1:0] pc_plus_4,
  output logic [WIDTH-1:0] branch_target
);

  typedef enum logic [3:0] {
    OP_AND   = 4'b0000,
    OP_ORR   = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_EOR   = 4'b0011,
    OP_SUB   = 4'b0110,
    OP_PASSB = 4'b0111,
    OP_NOR   = 4'b1100,
    OP_ILL   = 4'b1111
  } alu_op_e;

  alu_op_e          op_d;
  logic             illegal_d;
  logic [WIDTH-1:0] result_d;
  logic             carry_d;
  logic             overflow_d;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum_wide;

  // ALU control decode.
  // NOTE: each variable gets a default at the top of an always_comb block.
  // Without it, any path that skips an assignment would infer a latch.
  always_comb begin
    op_d      = OP_ADD;
    illegal_d = 1'b0;
    if (alu_op1) begin
      unique case (instruction_part)
        11'b10001011000: op_d = OP_ADD;
        11'b11001011000: op_d = OP_SUB;
        11'b10001010000: op_d = OP_AND;
        11'b10101010000: op_d = OP_ORR;
        11'b11001010000: op_d = OP_EOR;
        11'b11101010000: op_d = OP_NOR;
        default: begin
          op_d      = OP_ILL;
          illegal_d = 1'b1;
        end
      endcase
    end else if (alu_op0) begin
      op_d = OP_PASSB;
    end
  end

  // One shared adder serves both ADD and SUB. For SUB, B is inverted and the
  // carry-in is 1, so the adder computes A + ~B + 1.
  assign b_eff    = (op_d == OP_SUB) ? ~input_data_2 : input_data_2;
  assign sum_wide = {1'b0, input_data_1} + {1'b0, b_eff}
                  + {{WIDTH{1'b0}}, (op_d == OP_SUB)};

  always_comb begin
    result_d   = '0;
    carry_d    = 1'b0;
    overflow_d = 1'b0;
    case (op_d)
      OP_AND:   result_d = input_data_1 & input_data_2;
      OP_ORR:   result_d = input_data_1 | input_data_2;
      OP_EOR:   result_d = input_data_1 ^ input_data_2;
      OP_NOR:   result_d = ~(input_data_1 | input_data_2);
      OP_PASSB: result_d = input_data_2;
      OP_ADD, OP_SUB: begin
        result_d   = sum_wide[WIDTH-1:0];
        carry_d    = sum_wide[WIDTH];
        // Signed overflow: both addends have the same sign and the sum
        // has the other sign.
        overflow_d = (input_data_1[WIDTH-1] == b_eff[WIDTH-1]) &&
                     (sum_wide[WIDTH-1] != input_data_1[WIDTH-1]);
      end
      default:  result_d = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments. Every register
  // then samples values from before the clock edge, so the order of the
  // statements does not matter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid       <= 1'b0;
      operation_code  <= 4'b0000;
      output_data     <= '0;
      output_zero     <= 1'b0;
      output_carry    <= 1'b0;
      output_overflow <= 1'b0;
      illegal_op      <= 1'b0;
      pc_plus_4       <= '0;
      branch_target   <= '0;
    end else begin
      out_valid       <= in_valid;
      operation_code  <= op_d;
      output_data     <= result_d;
      output_zero     <= (result_d == '0);
      output_carry    <= carry_d;
      output_overflow <= overflow_d;
      illegal_op      <= illegal_d;
      pc_plus_4       <= pc + WIDTH'(PC_INCREMENT);
      branch_target   <= pc + branch_offset;
    end
  end

endmodule

// File: tb/tb_alu_execute_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_execute_unit
// Self-checking bench for alu_execute_unit. It runs in this order:
//   1. reset behaviour
//   2. a table of directed vectors
//   3. hand-written sequences for mid-cycle reset and in_valid=0
//   4. randomized transactions checked against a behavioural model
// -----------------------------------------------------------------------------
module tb_alu_execute_unit;

  localparam int W = 64;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          alu_op1, alu_op0;
  logic [10:0]   instruction_part;
  logic [W-1:0]  input_data_1, input_data_2, pc, branch_offset;
  logic          out_valid;
  logic [3:0]    operation_code;
  logic [W-1:0]  output_data;
  logic          output_zero, output_carry, output_overflow, illegal_op;
  logic [W-1:0]  pc_plus_4, branch_target;

  int checks = 0;
  int errors = 0;

  alu_execute_unit #(.WIDTH(W), .PC_INCREMENT(4)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid),
    .alu_op1(alu_op1), .alu_op0(alu_op0),
    .instruction_part(instruction_part),
    .input_data_1(input_data_1), .input_data_2(input_data_2),
    .pc(pc), .branch_offset(branch_offset),
    .out_valid(out_valid), .operation_code(operation_code),
    .output_data(output_data), .output_zero(output_zero),
    .output_carry(output_carry), .output_overflow(output_overflow),
    .illegal_op(illegal_op), .pc_plus_4(pc_plus_4),
    .branch_target(branch_target)
  );

  always #5 clock = ~clock;

  localparam logic [10:0] I_ADD = 11'b10001011000;
  localparam logic [10:0] I_SUB = 11'b11001011000;
  localparam logic [10:0] I_AND = 11'b10001010000;
  localparam logic [10:0] I_ORR = 11'b10101010000;
  localparam logic [10:0] I_EOR = 11'b11001010000;
  localparam logic [10:0] I_NOR = 11'b11101010000;

  typedef struct {
    logic [1:0]   aluop;
    logic [10:0]  instr;
    logic [W-1:0] a, b, pc, off;
    logic [3:0]   e_op;
    logic [W-1:0] e_res;
    logic         e_zero, e_carry, e_ovf, e_ill;
    logic [W-1:0] e_pc4, e_bt;
  } vec_t;

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input vec_t t);
    in_valid         = v;
    {alu_op1, alu_op0} = t.aluop;
    instruction_part = t.instr;
    input_data_1     = t.a;
    input_data_2     = t.b;
    pc               = t.pc;
    branch_offset    = t.off;
  endtask

  task automatic check_outputs(input string tag, input logic ev, input vec_t t);
    check({tag, " valid"},    W'(out_valid),       W'(ev));
    check({tag, " op"},       W'(operation_code),  W'(t.e_op));
    check({tag, " result"},   output_data,         t.e_res);
    check({tag, " zero"},     W'(output_zero),     W'(t.e_zero));
    check({tag, " carry"},    W'(output_carry),    W'(t.e_carry));
    check({tag, " overflow"}, W'(output_overflow), W'(t.e_ovf));
    check({tag, " illegal"},  W'(illegal_op),      W'(t.e_ill));
    check({tag, " pc_plus_4"}, pc_plus_4,          t.e_pc4);
    check({tag, " br_target"}, branch_target,      t.e_bt);
  endtask

  // Reference model, built from the arithmetic rules rather than from
  // gate-level structure. The carry of a subtract is "no borrow", i.e.
  // a >= b unsigned. Overflow means the exact signed result differs from
  // the signed value of the wrapped result.
  function automatic vec_t model(input vec_t t);
    vec_t r = t;
    logic [W:0]          wide;
    logic signed [W+1:0] exact;
    r.e_ill = 1'b0; r.e_carry = 1'b0; r.e_ovf = 1'b0;
    if (t.aluop == 2'b00)      r.e_op = 4'b0010;
    else if (t.aluop == 2'b01) r.e_op = 4'b0111;
    else begin
      case (t.instr)
        I_ADD: r.e_op = 4'b0010;
        I_SUB: r.e_op = 4'b0110;
        I_AND: r.e_op = 4'b0000;
        I_ORR: r.e_op = 4'b0001;
        I_EOR: r.e_op = 4'b0011;
        I_NOR: r.e_op = 4'b1100;
        default: begin r.e_op = 4'b1111; r.e_ill = 1'b1; end
      endcase
    end
    case (r.e_op)
      4'b0000: r.e_res = t.a & t.b;
      4'b0001: r.e_res = t.a | t.b;
      4'b0011: r.e_res = t.a ^ t.b;
      4'b1100: r.e_res = ~(t.a | t.b);
      4'b0111: r.e_res = t.b;
      4'b0010: begin
        wide      = {1'b0, t.a} + {1'b0, t.b};
        r.e_res   = wide[W-1:0];
        r.e_carry = wide[W];
        exact     = $signed({{2{t.a[W-1]}}, t.a}) + $signed({{2{t.b[W-1]}}, t.b});
        r.e_ovf   = (exact != $signed({{2{r.e_res[W-1]}}, r.e_res}));
      end
      4'b0110: begin
        r.e_res   = t.a - t.b;
        r.e_carry = (t.a >= t.b);
        exact     = $signed({{2{t.a[W-1]}}, t.a}) - $signed({{2{t.b[W-1]}}, t.b});
        r.e_ovf   = (exact != $signed({{2{r.e_res[W-1]}}, r.e_res}));
      end
      default: r.e_res = '0;
    endcase
    r.e_zero = (r.e_res == '0);
    r.e_pc4  = t.pc + 64'd4;
    r.e_bt   = t.pc + t.off;
    return r;
  endfunction

  function automatic logic [W-1:0] rand64();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0: v = '0;
      1: v = '1;
      2: v = 64'h8000_0000_0000_0000;
      3: v = 64'h7FFF_FFFF_FFFF_FFFF;
      default: v = {$urandom(), $urandom()};
    endcase
    return v;
  endfunction

  vec_t vecs[14];
  vec_t zero_v;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //           aluop  instr   a                       b                       pc                      off                     op     result                  z     c     v     ill   pc4                     bt
    vecs[0]  = '{2'b10, I_ADD, 64'd5,                  64'd7,                  64'd0,                  64'd0,                  4'h2, 64'd12,                 1'b0, 1'b0, 1'b0, 1'b0, 64'd4,                  64'd0};
    vecs[1]  = '{2'b10, I_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                  64'd0,                  64'd0,                  4'h2, 64'd0,                  1'b1, 1'b1, 1'b0, 1'b0, 64'd4,                  64'd0};
    vecs[2]  = '{2'b10, I_SUB, 64'h1234,               64'h1234,               64'd0,                  64'd0,                  4'h6, 64'd0,                  1'b1, 1'b1, 1'b0, 1'b0, 64'd4,                  64'd0};
    vecs[3]  = '{2'b10, I_SUB, 64'h8000_0000_0000_0000, 64'd1,                  64'd0,                  64'd0,                  4'h6, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0, 64'd4,                  64'd0};
    vecs[4]  = '{2'b11, I_AND, 64'hF0F0,               64'hFF00,               64'd0,                  64'd0,                  4'h0, 64'hF000,               1'b0, 1'b0, 1'b0, 1'b0, 64'd4,                  64'd0};
    vecs[5]  = '{2'b10, I_ORR, 64'hF0F0,               64'hFF00,               64'd0,                  64'd0,                  4'h1, 64'hFFF0,               1'b0, 1'b0, 1'b0, 1'b0, 64'd4,                  64'd0};
    vecs[6]  = '{2'b10, I_EOR, 64'hF0F0,               64'hFF00,               64'd0,                  64'd0,                  4'h3, 64'h0FF0,               1'b0, 1'b0, 1'b0, 1'b0, 64'd4,                  64'd0};
    vecs[7]  = '{2'b10, I_NOR, 64'hF0F0,               64'hFF00,               64'd0,                  64'd0,                  4'hC, 64'hFFFF_FFFF_FFFF_000F, 1'b0, 1'b0, 1'b0, 1'b0, 64'd4,                  64'd0};
    vecs[8]  = '{2'b01, I_ADD, 64'd5,                  64'd0,                  64'd0,                  64'd0,                  4'h7, 64'd0,                  1'b1, 1'b0, 1'b0, 1'b0, 64'd4,                  64'd0};
    vecs[9]  = '{2'b01, I_SUB, 64'd5,                  64'd3,                  64'd0,                  64'd0,                  4'h7, 64'd3,                  1'b0, 1'b0, 1'b0, 1'b0, 64'd4,                  64'd0};
    vecs[10] = '{2'b00, 11'd0, 64'h100,                64'h8,                  64'd0,                  64'd0,                  4'h2, 64'h108,                1'b0, 1'b0, 1'b0, 1'b0, 64'd4,                  64'd0};
    vecs[11] = '{2'b10, 11'd0, 64'd5,                  64'd7,                  64'd0,                  64'd0,                  4'hF, 64'd0,                  1'b1, 1'b0, 1'b0, 1'b1, 64'd4,                  64'd0};
    vecs[12] = '{2'b00, I_AND, 64'd0,                  64'd0,                  64'h40,                 64'hFFFF_FFFF_FFFF_FFF8, 4'h2, 64'd0,                  1'b1, 1'b0, 1'b0, 1'b0, 64'h44,                 64'h38};
    vecs[13] = '{2'b00, 11'd0, 64'd1,                  64'd2,                  64'hFFFF_FFFF_FFFF_FFFC, 64'd4,                  4'h2, 64'd3,                  1'b0, 1'b0, 1'b0, 1'b0, 64'd0,                  64'd0};
    zero_v   = '{2'b00, 11'd0, 64'd0, 64'd0, 64'd0, 64'd0, 4'h0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0};

    // Reset held while random inputs are applied.
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vec_t r;
      r.aluop = 2'($urandom()); r.instr = 11'($urandom());
      r.a = rand64(); r.b = rand64(); r.pc = rand64(); r.off = rand64();
      drive(1'b1, r);
      @(posedge clock); #1;
      check_outputs("reset_hold", 1'b0, zero_v);
    end
    reset = 1'b1;

    // Directed table.
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, vecs[i]);
      @(posedge clock); #1;
      check_outputs($sformatf("vec%0d", i), 1'b1, vecs[i]);
    end

    // in_valid=0: the result registers still load, and out_valid drops.
    drive(1'b0, vecs[7]);
    @(posedge clock); #1;
    check_outputs("invalid_load", 1'b0, vecs[7]);

    // A reset asserted mid-cycle clears the pending result without a clock.
    drive(1'b1, vecs[3]);
    @(posedge clock); #2;
    reset = 1'b0;
    #1;
    check_outputs("mid_reset", 1'b0, zero_v);
    #1 reset = 1'b1;
    drive(1'b1, vecs[0]);
    @(posedge clock); #1;
    check_outputs("post_reset", 1'b1, vecs[0]);

    // Randomized transactions against the model.
    for (int i = 0; i < 300; i++) begin
      vec_t r;
      logic v;
      logic [10:0] legal[6];
      legal = '{I_ADD, I_SUB, I_AND, I_ORR, I_EOR, I_NOR};
      r.aluop = 2'($urandom());
      r.instr = ($urandom_range(0, 5) == 0) ? 11'($urandom())
                                            : legal[$urandom_range(0, 5)];
      r.a = rand64(); r.b = ($urandom_range(0, 7) == 0) ? r.a : rand64();
      r.pc = rand64(); r.off = rand64();
      r = model(r);
      v = 1'($urandom());
      drive(v, r);
      @(posedge clock); #1;
      check_outputs($sformatf("rand%0d", i), v, r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_execute_unit.md
Name: alu_execute_unit

Overview:
Execute stage of the single-cycle LEGv8-style datapath. It merges three functions: ALU-control decode, a 64-bit ALU, and two 64-bit adders (PC+4 and branch target). Results are registered, so the block has 1-cycle latency. It sits between the register bank / sign-extend / ALUSrc mux and the data memory / PC mux.

Parameters:
WIDTH, 64, datapath width of operands, results and PC.
PC_INCREMENT, 4, constant added to pc for the sequential next PC.

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
in_valid  input  1  operands and controls valid this cycle
alu_op1  input  1  ALUOp bit 1 from the control unit
alu_op0  input  1  ALUOp bit 0 from the control unit
instruction_part  input  11  instruction[31:21] opcode field
input_data_1  input  WIDTH  ALU operand A (Rn data)
input_data_2  input  WIDTH  ALU operand B (ALUSrc mux output)
pc  input  WIDTH  current PC
branch_offset  input  WIDTH  sign-extended offset, already shifted left by 2
out_valid  output  1  registered outputs valid
operation_code  output  4  registered decoded ALU operation
output_data  output  WIDTH  registered ALU result
output_zero  output  1  registered: output_data == 0
output_carry  output  1  registered carry-out (add/sub only, else 0)
output_overflow  output  1  registered signed overflow (add/sub only, else 0)
illegal_op  output  1  registered: R-type opcode not recognised
pc_plus_4  output  WIDTH  registered pc + PC_INCREMENT
branch_target  output  WIDTH  registered pc + branch_offset

Behaviour:
- Reset asserted (reset=0), asynchronous:
  - out_valid=0; operation_code=0000; every data output 0.
  - output_zero=0; output_carry=0; output_overflow=0; illegal_op=0.
  - Reset asserted mid-operation discards the pending result immediately.
- ALU control decode (combinational, captured into operation_code):
  - {op1,op0}=00: 0010 (ADD; load/store address).
  - 01: 0111 (pass B; CBZ).
  - 1x: R-type, decoded from instruction_part:
    - 10001011000 ADD -> 0010
    - 11001011000 SUB -> 0110
    - 10001010000 AND -> 0000
    - 10101010000 ORR -> 0001
    - 11001010000 EOR -> 0011
    - 11101010000 NOR -> 1100
    - any other value -> 1111, with illegal_op=1.
- ALU operations:
  - 0000 A&B
  - 0001 A|B
  - 0011 A^B
  - 0010 A+B
  - 0110 A-B (two's complement, A+~B+1)
  - 0111 B
  - 1100 ~(A|B)
  - 1111 result 0
- Arithmetic:
  - All arithmetic is modulo 2^WIDTH; results wrap silently.
  - output_carry is bit WIDTH of the add, or of A+~B+1 for subtract.
  - output_overflow = operand signs equal (B inverted for SUB) and result sign differs.
- output_zero is computed from the final result, so it is 1 for op 1111.
- Adders are unconditional modulo-2^WIDTH adds. No carry output from the adders.
- Pipeline:
  - On every rising edge with reset=1, all outputs load from the current inputs.
  - out_valid <= in_valid.
  - Outputs are registered even when in_valid=0 (no stall/hold). Consumers qualify them with out_valid.
  - Latency 1 cycle, throughput 1 per cycle, no backpressure.

Test Plan:
- Reset: hold reset=0 with random inputs, then release; all outputs are 0 while held; after the first edge with in_valid=1, out_valid=1.
- R-type ADD with op=10, instr=10001011000, A=5, B=7: result 12, op 0010, zero=0. Then A=FFFF_FFFF_FFFF_FFFF, B=1: result 0, zero=1, carry=1, overflow=0.
- SUB with instr=11001011000, A=B=0x1234: result 0, zero=1, carry=1. Then A=8000_0000_0000_0000, B=1: result 7FFF_FFFF_FFFF_FFFF, overflow=1.
- Logic ops with A=F0F0, B=FF00:
  - AND -> F000
  - ORR -> FFF0
  - EOR -> 0FF0
  - NOR -> FFFF_FFFF_FFFF_000F
- CBZ: op=01, B=0 -> result 0, zero=1, op 0111. Then B=3 -> zero=0.
- LDUR: op=00, A=0x100, B=0x8 -> result 0x108. Illegal: op=10, instr=00000000000 -> illegal_op=1, op 1111, result 0. Adders: pc=0x40, offset=-8 -> pc_plus_4=0x44, branch_target=0x38. pc=FFFF_FFFF_FFFF_FFFC -> pc_plus_4=0 (wrap).
